ir_scan_controller: RTL and testbench

Time-multiplexes one IR frequency detector across NUM_CH IR sensor inputs. Per channel: selects the sensor via the detector-input mux, restarts the detector, waits a settle interval, then waits for a decision or a timeout, and stores the result. After each full sweep it publishes the strongest channel. Sits between the sensor mux and the IR detector, feeding steering/targeting logic.

---
 rtl/ir_scan_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_ir_scan_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_scan_controller.sv
// Purpose : time-multiplexes one IR frequency detector across NUM_CH sensors, publishes the strongest channel per sweep.
// Latency : per channel 1 (SELECT) + SETTLE_CYCLES + measure cycles + 1 (STORE); +1 (FINISH) per sweep.
// Backpressure: none; det_done is the only handshake, bounded by TIMEOUT_CYCLES. enable is a level, and a running sweep always completes.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   enable_i, ch_mask_i   run sweeps while high; mask of channels, latched at sweep start
//   ch_sel_o, det_rst_o   detector input mux select; one-cycle detector restart pulse
//   det_done_i, det_decision_i  detector decision level and code (0 = no signal)
//   ch_result_o/ch_valid_o/ch_timeout_o  per-channel stored results
//   best_ch_o/best_dec_o/best_found_o    strongest channel of the last completed sweep
//   scan_done_o, busy_o   sweep-end pulse; high whenever not idle
module ir_scan_controller #(
    parameter int NUM_CH         = 4,
    parameter int SEL_W          = 2,
    parameter int DEC_W          = 3,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [NUM_CH-1:0]       ch_mask_i,
    output logic [SEL_W-1:0]        ch_sel_o,
    output logic                    det_rst_o,
    input  logic                    det_done_i,
    input  logic [DEC_W-1:0]        det_decision_i,
    output logic [NUM_CH*DEC_W-1:0] ch_result_o,
    output logic [NUM_CH-1:0]       ch_valid_o,
    output logic [NUM_CH-1:0]       ch_timeout_o,
    output logic [SEL_W-1:0]        best_ch_o,
    output logic [DEC_W-1:0]        best_dec_o,
    output logic                    best_found_o,
    output logic                    scan_done_o,
    output logic                    busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // SETTLE_CYCLES is assumed to be at least 1.
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [2:0] {
        IDLE, SELECT, SETTLE, MEASURE, STORE, FINISH
    } state_t;

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          cur_q, cur_d;
    logic [NUM_CH-1:0]         mask_q, mask_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DEC_W-1:0]          cap_dec_q, cap_dec_d;
    logic                      cap_to_q, cap_to_d;
    logic [DEC_W-1:0]          acc_dec_q, acc_dec_d;
    logic [SEL_W-1:0]          acc_ch_q, acc_ch_d;
    logic [NUM_CH*DEC_W-1:0]   ch_result_q, ch_result_d;
    logic [NUM_CH-1:0]         ch_valid_q, ch_valid_d;
    logic [NUM_CH-1:0]         ch_timeout_q, ch_timeout_d;
    logic [SEL_W-1:0]          best_ch_q, best_ch_d;
    logic [DEC_W-1:0]          best_dec_q, best_dec_d;
    logic                      best_found_q, best_found_d;

    logic [SEL_W-1:0]          first_ch;
    logic [SEL_W-1:0]          next_ch;
    logic                      next_found;

    // Lowest set bit of the live mask: first channel of a new sweep.
    always_comb begin
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) first_ch = SEL_W'(i);
        end
    end

    // Lowest set bit of the latched mask strictly above the current channel.
    always_comb begin
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (SEL_W'(i) > cur_q)) begin
                next_ch    = SEL_W'(i);
                next_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i && (|ch_mask_i)) state_d = SELECT;
            SELECT:  state_d = SETTLE;
            SETTLE:  if (cnt_q == SETTLE_LAST) state_d = MEASURE;
            MEASURE: if (det_done_i || (cnt_q == TIMEOUT_LAST)) state_d = STORE;
            STORE:   state_d = next_found ? SELECT : FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cur_d        = cur_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        cap_dec_d    = cap_dec_q;
        cap_to_d     = cap_to_q;
        acc_dec_d    = acc_dec_q;
        acc_ch_d     = acc_ch_q;
        ch_result_d  = ch_result_q;
        ch_valid_d   = ch_valid_q;
        ch_timeout_d = ch_timeout_q;
        best_ch_d    = best_ch_q;
        best_dec_d   = best_dec_q;
        best_found_d = best_found_q;
        case (state_q)
            IDLE: begin
                if (enable_i && (|ch_mask_i)) begin
                    mask_d    = ch_mask_i;
                    cur_d     = first_ch;
                    acc_dec_d = '0;
                    acc_ch_d  = '0;
                end
            end
            SELECT: cnt_d = '0;
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) cnt_d = '0;
                else                      cnt_d = cnt_q + CNT_W'(1);
            end
            MEASURE: begin
                // det_done wins over the timeout in the terminal cycle.
                if (det_done_i) begin
                    cap_dec_d = det_decision_i;
                    cap_to_d  = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cap_dec_d = '0;
                    cap_to_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STORE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (SEL_W'(i) == cur_q) begin
                        ch_result_d[i*DEC_W +: DEC_W] = cap_dec_q;
                        ch_valid_d[i]                 = 1'b1;
                        ch_timeout_d[i]               = cap_to_q;
                    end
                end
                // Strict compare: on a tie the earlier (lower) channel is kept.
                if (cap_dec_q > acc_dec_q) begin
                    acc_dec_d = cap_dec_q;
                    acc_ch_d  = cur_q;
                end
                if (next_found) cur_d = next_ch;
            end
            FINISH: begin
                best_ch_d    = acc_ch_q;
                best_dec_d   = acc_dec_q;
                best_found_d = (acc_dec_q != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_q        <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            cap_dec_q    <= '0;
            cap_to_q     <= 1'b0;
            acc_dec_q    <= '0;
            acc_ch_q     <= '0;
            ch_result_q  <= '0;
            ch_valid_q   <= '0;
            ch_timeout_q <= '0;
            best_ch_q    <= '0;
            best_dec_q   <= '0;
            best_found_q <= 1'b0;
        end else begin
            cur_q        <= cur_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            cap_dec_q    <= cap_dec_d;
            cap_to_q     <= cap_to_d;
            acc_dec_q    <= acc_dec_d;
            acc_ch_q     <= acc_ch_d;
            ch_result_q  <= ch_result_d;
            ch_valid_q   <= ch_valid_d;
            ch_timeout_q <= ch_timeout_d;
            best_ch_q    <= best_ch_d;
            best_dec_q   <= best_dec_d;
            best_found_q <= best_found_d;
        end
    end

    // Output logic. cur_q only changes on entry to SELECT, so it doubles as the
    // mux select and holds until the next channel is selected.
    always_comb begin
        det_rst_o   = (state_q == SELECT);
        scan_done_o = (state_q == FINISH);
        busy_o      = (state_q != IDLE);
    end

    assign ch_sel_o     = cur_q;
    assign ch_result_o  = ch_result_q;
    assign ch_valid_o   = ch_valid_q;
    assign ch_timeout_o = ch_timeout_q;
    assign best_ch_o    = best_ch_q;
    assign best_dec_o   = best_dec_q;
    assign best_found_o = best_found_q;

endmodule

// File: tb/tb_ir_scan_controller.sv
// Bench for ir_scan_controller: table of full sweeps plus hand-written latency,
// enable-drop and mid-sweep reset sequences, against a simple detector model.
module tb_ir_scan_controller;

    localparam int DLY = 10;   // detector model: det_done this many cycles after det_rst

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [1:0]  ch_sel;
    logic        det_rst;
    logic        det_done;
    logic [2:0]  det_decision;
    logic [11:0] ch_result;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_timeout;
    logic [1:0]  best_ch;
    logic [2:0]  best_dec;
    logic        best_found;
    logic        scan_done;
    logic        busy;

    ir_scan_controller #(
        .NUM_CH(4), .SEL_W(2), .DEC_W(3), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .ch_mask_i(ch_mask),
        .ch_sel_o(ch_sel), .det_rst_o(det_rst), .det_done_i(det_done),
        .det_decision_i(det_decision), .ch_result_o(ch_result), .ch_valid_o(ch_valid),
        .ch_timeout_o(ch_timeout), .best_ch_o(best_ch), .best_dec_o(best_dec),
        .best_found_o(best_found), .scan_done_o(scan_done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Detector model controls and monitors
    logic [11:0] decs;        // per-channel decision, ch i at [3*i +: 3]
    logic [3:0]  never_mask;  // channels that never assert det_done
    logic        hold_done;   // det_done forced high
    bit          m_active;
    int          m_cnt, m_ch;
    int          sel_log[$];
    int          sd_cnt, busy_seen;
    int          checks, errors;
    logic [1:0]  prev_bch;
    logic [2:0]  prev_bdec;
    logic        prev_bf;

    typedef struct {
        logic        rst_first;
        logic [3:0]  mask;
        logic [11:0] decs;
        logic [3:0]  never;
        logic        hold;
        logic [11:0] exp_res;
        logic [3:0]  exp_vld;
        logic [3:0]  exp_to;
        logic [1:0]  exp_bch;
        logic [2:0]  exp_bdec;
        logic        exp_bf;
    } vec_t;

    typedef struct {
        logic       never;
        logic       hold;
        logic [2:0] dec;
        int         lat;
        logic [2:0] res;
        logic       to;
    } lat_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // One clock: step to the negedge, then advance the detector model and monitors.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            m_active = 1'b0;
            m_cnt    = 0;
        end else if (det_rst) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_ch     = int'(ch_sel);
            sel_log.push_back(int'(ch_sel));
        end else if (m_active && m_cnt < 100000) begin
            m_cnt++;
        end
        if (scan_done) sd_cnt++;
        if (busy) busy_seen++;
        det_done     = hold_done || (m_active && !never_mask[m_ch] && m_cnt >= DLY);
        det_decision = det_done ? decs[m_ch*3 +: 3] : 3'd0;
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, ch_sel, det_rst, ch_result, ch_valid, ch_timeout,
                best_ch, best_dec, best_found, scan_done, busy};
    endfunction

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        prev_bch  = '0;
        prev_bdec = '0;
        prev_bf   = 1'b0;
    endtask

    task automatic wait_scan_done(input string name);
        int n = 0;
        while (!scan_done && n < 5000) begin
            tick();
            n++;
        end
        if (!scan_done) expire(name);
    endtask

    task automatic wait_sel(input string name, input int ch);
        int n = 0;
        while (!(det_rst && int'(ch_sel) == ch) && n < 2000) begin
            tick();
            n++;
        end
        if (!(det_rst && int'(ch_sel) == ch)) expire(name);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] exp_seq, act_seq;
        if (v.rst_first) do_reset();
        ch_mask    = v.mask;
        decs       = v.decs;
        never_mask = v.never;
        hold_done  = v.hold;
        sel_log.delete();
        sd_cnt = 0;
        enable = 1'b1;
        wait_scan_done($sformatf("v%0d_scan_done", idx));
        enable = 1'b0;
        // best_* still show the previous sweep during FINISH
        chk($sformatf("v%0d_best_hold", idx), 32'({best_ch, best_dec, best_found}),
            32'({prev_bch, prev_bdec, prev_bf}));
        tick();
        tick();
        exp_seq = '0;
        for (int i = 0; i < 4; i++) if (v.mask[i]) exp_seq = exp_seq * 16 + 32'(i + 1);
        act_seq = '0;
        foreach (sel_log[i]) act_seq = act_seq * 16 + 32'(sel_log[i] + 1);
        chk($sformatf("v%0d_sel_seq", idx), act_seq, exp_seq);
        chk($sformatf("v%0d_result", idx), 32'(ch_result), 32'(v.exp_res));
        chk($sformatf("v%0d_valid", idx), 32'(ch_valid), 32'(v.exp_vld));
        chk($sformatf("v%0d_timeout", idx), 32'(ch_timeout), 32'(v.exp_to));
        chk($sformatf("v%0d_best_ch", idx), 32'(best_ch), 32'(v.exp_bch));
        chk($sformatf("v%0d_best_dec", idx), 32'(best_dec), 32'(v.exp_bdec));
        chk($sformatf("v%0d_best_found", idx), 32'(best_found), 32'(v.exp_bf));
        chk($sformatf("v%0d_scan_pulses", idx), 32'(sd_cnt), 32'd1);
        chk($sformatf("v%0d_busy_idle", idx), 32'(busy), 32'd0);
        prev_bch  = v.exp_bch;
        prev_bdec = v.exp_bdec;
        prev_bf   = v.exp_bf;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        lat_t lats[3];
        int   n;

        //            rst   mask   decs     never hold  exp_res  vld   to    bch   bdec  bf
        vecs[0] = '{1'b1, 4'hF, 12'h699, 4'h0, 1'b0, 12'h699, 4'hF, 4'h0, 2'd1, 3'd3, 1'b1};
        vecs[1] = '{1'b0, 4'hA, 12'h428, 4'h0, 1'b0, 12'h4A9, 4'hF, 4'h0, 2'd1, 3'd5, 1'b1};
        vecs[2] = '{1'b1, 4'h5, 12'hEBD, 4'h0, 1'b0, 12'h085, 4'h5, 4'h0, 2'd0, 3'd5, 1'b1};
        vecs[3] = '{1'b1, 4'hF, 12'h991, 4'h4, 1'b0, 12'h811, 4'hF, 4'h4, 2'd3, 3'd4, 1'b1};
        vecs[4] = '{1'b0, 4'h4, 12'h0C0, 4'h0, 1'b0, 12'h8D1, 4'hF, 4'h0, 2'd2, 3'd3, 1'b1};
        vecs[5] = '{1'b1, 4'hF, 12'h000, 4'h0, 1'b1, 12'h000, 4'hF, 4'h0, 2'd0, 3'd0, 1'b0};
        vecs[6] = '{1'b1, 4'h8, 12'hE00, 4'h0, 1'b0, 12'hE00, 4'h8, 4'h0, 2'd3, 3'd7, 1'b1};

        // det_rst negedge to ch_valid visible: 1 SELECT... counted from the SELECT cycle
        //          never hold  dec   lat res   to
        lats[0] = '{1'b0, 1'b0, 3'd3, 12, 3'd3, 1'b0};  // done 10 cycles after det_rst
        lats[1] = '{1'b1, 1'b0, 3'd3, 56, 3'd0, 1'b1};  // STORE 50 cycles after MEASURE entry
        lats[2] = '{1'b0, 1'b1, 3'd5, 7,  3'd5, 1'b0};  // held done captured first MEASURE cycle

        checks = 0;
        errors = 0;
        rst = 1'b1;
        enable = 1'b0;
        ch_mask = '0;
        decs = '0;
        never_mask = '0;
        hold_done = 1'b0;
        det_done = 1'b0;
        det_decision = '0;
        m_active = 1'b0;
        m_cnt = 0;
        m_ch = 0;
        sd_cnt = 0;
        busy_seen = 0;
        tick();
        chk("reset_outputs", all_outs(), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Per-channel latency: normal decision, timeout, det_done held through SETTLE
        for (int i = 0; i < 3; i++) begin
            do_reset();
            ch_mask    = 4'b0001;
            decs       = {9'd0, lats[i].dec};
            never_mask = {3'b000, lats[i].never};
            hold_done  = lats[i].hold;
            enable     = 1'b1;
            wait_sel($sformatf("lat%0d_select", i), 0);
            n = 0;
            while (!ch_valid[0] && n < 200) begin
                tick();
                n++;
            end
            chk($sformatf("lat%0d_cycles", i), 32'(n), 32'(lats[i].lat));
            wait_scan_done($sformatf("lat%0d_scan_done", i));
            enable = 1'b0;
            tick();
            chk($sformatf("lat%0d_result", i), 32'(ch_result[2:0]), 32'(lats[i].res));
            chk($sformatf("lat%0d_timeout", i), 32'(ch_timeout[0]), 32'(lats[i].to));
        end
        hold_done = 1'b0;

        // enable dropped during ch1 MEASURE: sweep still completes, then rests idle
        do_reset();
        ch_mask    = 4'hF;
        decs       = 12'h699;
        never_mask = '0;
        sel_log.delete();
        sd_cnt = 0;
        enable = 1'b1;
        wait_sel("endrop_sel1", 1);
        repeat (7) tick();
        enable = 1'b0;
        wait_scan_done("endrop_scan_done");
        chk("endrop_selects", 32'(sel_log.size()), 32'd4);
        tick();
        chk("endrop_busy", 32'(busy), 32'd0);
        chk("endrop_valid", 32'(ch_valid), 32'hF);
        chk("endrop_pulses", 32'(sd_cnt), 32'd1);
        busy_seen = 0;
        n = sel_log.size();
        repeat (20) tick();
        chk("endrop_stays_idle", 32'(busy_seen), 32'd0);
        ch_mask = 4'h0;
        enable  = 1'b1;
        repeat (20) tick();
        chk("zero_mask_busy", 32'(busy_seen), 32'd0);
        chk("zero_mask_no_select", 32'(sel_log.size()), 32'(n));
        enable = 1'b0;

        // Reset during ch2 SETTLE, then restart at the lowest set mask bit
        do_reset();
        ch_mask = 4'b1110;
        decs    = 12'h699;
        enable  = 1'b1;
        wait_sel("midrst_sel2", 2);
        tick();
        tick();
        chk("midrst_pre_valid", 32'(ch_valid), 32'h2);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", all_outs(), 32'd0);
        sd_cnt = 0;
        repeat (3) tick();
        rst = 1'b0;
        sel_log.delete();
        n = 0;
        while (sel_log.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        chk("midrst_no_scan_done", 32'(sd_cnt), 32'd0);
        if (sel_log.size() == 0) expire("midrst_restart");
        else chk("midrst_first_sel", 32'(sel_log[0]), 32'd1);
        wait_scan_done("midrst_scan_done");
        enable = 1'b0;
        tick();
        tick();
        chk("midrst_valid", 32'(ch_valid), 32'hE);
        chk("midrst_result", 32'(ch_result), 32'h698);
        chk("midrst_best", 32'({best_ch, best_dec, best_found}), 32'({2'd1, 3'd3, 1'b1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
